// File: rtl/pwm_pkg.sv
// pwm_pkg: register map of the multi-channel PWM peripheral
package pwm_pkg;
  localparam int unsigned ADDR_OUT_EN = 0;
  localparam int unsigned ADDR_PWM_EN = 1;
  localparam int unsigned ADDR_PERIOD = 2;
  localparam int unsigned ADDR_PRESC  = 3;
  localparam int unsigned ADDR_DUTY0  = 4;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaled PWM counter producing wrap and period-start pulses
module pwm_timebase #(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               wrap_o,
  output logic               period_start_o
);
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               period_start_q;
  logic               tick;
  // prescaler tick, counter wrap on the tick that reaches the period, next counts
  always_comb begin
    tick        = presc_cnt_q == presc_i;
    wrap_o      = tick && cnt_q == period_i;
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
    cnt_d       = wrap_o ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // counter state; period_start is high in the first cycle the counter is 0
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt_q    <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_cnt_q    <= presc_cnt_d;
      cnt_q          <= cnt_d;
      period_start_q <= wrap_o;
    end
  end
  assign cnt_o          = cnt_q;
  assign period_start_o = period_start_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM with staged config and shadowed duty/period/prescaler
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_re,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  logic [NUM_CH-1:0]  out_en_q, out_en_d, pwm_en_q, pwm_en_d, out_q, lvl;
  logic [CNT_W-1:0]   period_stg_q, period_stg_d, period_q, cnt;
  logic [PRESC_W-1:0] presc_stg_q, presc_stg_d, presc_q;
  logic [CNT_W-1:0]   duty_stg_q [NUM_CH];
  logic [CNT_W-1:0]   duty_stg_d [NUM_CH];
  logic [CNT_W-1:0]   duty_q [NUM_CH];
  logic [DATA_W-1:0]  rdata_q, rdata_d, rd;
  logic [31:0]        addr;
  logic               wrap;
  assign addr = 32'(cfg_addr);
  pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_tb (
    .clk           (clk),
    .rst           (rst),
    .period_i      (period_q),
    .presc_i       (presc_q),
    .cnt_o         (cnt),
    .wrap_o        (wrap),
    .period_start_o(period_start)
  );
  // register-file write decode and read mux; unmapped addresses read as zero
  always_comb begin
    out_en_d     = (cfg_we && addr == ADDR_OUT_EN) ? cfg_wdata[NUM_CH-1:0] : out_en_q;
    pwm_en_d     = (cfg_we && addr == ADDR_PWM_EN) ? cfg_wdata[NUM_CH-1:0] : pwm_en_q;
    period_stg_d = (cfg_we && addr == ADDR_PERIOD) ? cfg_wdata[CNT_W-1:0] : period_stg_q;
    presc_stg_d  = (cfg_we && addr == ADDR_PRESC) ? cfg_wdata[PRESC_W-1:0] : presc_stg_q;
    rd = addr == ADDR_OUT_EN ? DATA_W'(out_en_q) :
         addr == ADDR_PWM_EN ? DATA_W'(pwm_en_q) :
         addr == ADDR_PERIOD ? DATA_W'(period_stg_q) :
         addr == ADDR_PRESC  ? DATA_W'(presc_stg_q) : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_stg_d[i] = (cfg_we && addr == ADDR_DUTY0 + 32'(i)) ? cfg_wdata[CNT_W-1:0] : duty_stg_q[i];
      rd = addr == ADDR_DUTY0 + 32'(i) ? DATA_W'(duty_stg_q[i]) : rd;
    end
    rdata_d = cfg_re ? rd : rdata_q;
  end
  // staged configuration registers and read-data register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en_q     <= '0;
      pwm_en_q     <= '0;
      period_stg_q <= '1;
      presc_stg_q  <= '0;
      duty_stg_q   <= '{default: '0};
      rdata_q      <= '0;
    end else begin
      out_en_q     <= out_en_d;
      pwm_en_q     <= pwm_en_d;
      period_stg_q <= period_stg_d;
      presc_stg_q  <= presc_stg_d;
      duty_stg_q   <= duty_stg_d;
      rdata_q      <= rdata_d;
    end
  end
  // shadows pick up staged values only at the counter wrap, so a period never mixes settings
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '1;
      presc_q  <= '0;
      duty_q   <= '{default: '0};
    end else if (wrap) begin
      period_q <= period_stg_q;
      presc_q  <= presc_stg_q;
      duty_q   <= duty_stg_q;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign lvl[c] = (cnt < duty_q[c]) | (duty_q[c] > period_q);
  end
  // gated channel outputs; a disabled PWM on an enabled channel drives constant high
  always_ff @(posedge clk) begin
    out_q <= rst ? '0 : out_en_q & (~pwm_en_q | lvl);
  end
  assign out       = out_q;
  assign cfg_rdata = rdata_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: register vectors, duty/period measurement and shadow-update corner cases
module tb_pwm_multi_channel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_re = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic [15:0] out;
  logic        period_start;
  int pass_n = 0;
  int tot_n = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[17];

  pwm_multi_channel dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_re      (cfg_re),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .out         (out),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_re = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(logic [4:0] a, logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic rd(logic [4:0] a, logic [15:0] e, string nm);
    cfg_re = 1'b1;
    cfg_addr = a;
    exp_q.push_back(e);
    step();
    cfg_re = 1'b0;
    chk(nm, cfg_rdata, exp_q.pop_front());
  endtask

  task automatic wait_ps(int bound, output int n, output int nz);
    n = 0;
    nz = 0;
    do begin
      step();
      n++;
      if (out != 16'h0) nz++;
    end while (!period_start && n < bound);
    chk("ps_seen", period_start, 1);
  endtask

  task automatic measure(int per, int wj, logic [15:0] wd, output int hi, output int oth);
    hi = 0;
    oth = 0;
    for (int j = 0; j < per; j++) begin
      hi += int'(out[0]);
      if (j > 0 && period_start) oth++;
      if (out[15:1] != 15'h0) oth++;
      cfg_we = (j == wj);
      cfg_addr = 5'd4;
      cfg_wdata = wd;
      step();
    end
    cfg_we = 1'b0;
    chk("ps_end", period_start, 1);
  endtask

  initial begin
    int n, nz, hi, oth;
    vecs[0]  = '{1'b0, 5'd0,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 5'd1,  16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 5'd2,  16'h0000, 16'h00FF};
    vecs[3]  = '{1'b0, 5'd3,  16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 5'd4,  16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 5'd19, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 5'd31, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 5'd0,  16'hFFFF, 16'hFFFF};
    vecs[8]  = '{1'b1, 5'd1,  16'hA5A5, 16'hA5A5};
    vecs[9]  = '{1'b1, 5'd2,  16'h1234, 16'h0034};
    vecs[10] = '{1'b1, 5'd3,  16'hFF03, 16'h0003};
    vecs[11] = '{1'b1, 5'd4,  16'h0140, 16'h0040};
    vecs[12] = '{1'b1, 5'd19, 16'h00AB, 16'h00AB};
    vecs[13] = '{1'b1, 5'd20, 16'hFFFF, 16'h0000};
    vecs[14] = '{1'b1, 5'd31, 16'h5555, 16'h0000};
    vecs[15] = '{1'b1, 5'd7,  16'hBEEF, 16'h00EF};
    vecs[16] = '{1'b0, 5'd4,  16'h0000, 16'h0040};

    do_reset();
    chk("rst_out", out, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_ps", period_start, 0);
    wait_ps(400, n, nz);
    chk("first_ps_delay", n, 256);
    chk("idle_out", nz, 0);
    wait_ps(400, n, nz);
    chk("ps_interval", n, 256);
    chk("idle_out2", nz, 0);
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wd);
      rd(vecs[i].addr, vecs[i].exp, $sformatf("reg_vec%0d", i));
    end
    repeat (3) step();
    chk("rdata_hold", cfg_rdata, 16'h0040);

    do_reset();
    wr(5'd0, 16'h0001);
    wr(5'd1, 16'h0001);
    wr(5'd4, 16'd64);
    wait_ps(400, n, nz);
    chk("t2_lat0", out[0], 0);
    step();
    chk("t2_lat1", out[0], 1);
    wait_ps(300, n, nz);
    measure(256, -1, 16'h0, hi, oth);
    chk("t2_high", hi, 64);
    chk("t2_other", oth, 0);

    wr(5'd3, 16'd3);
    wr(5'd2, 16'd9);
    wr(5'd4, 16'd5);
    wait_ps(300, n, nz);
    measure(40, -1, 16'h0, hi, oth);
    measure(40, -1, 16'h0, hi, oth);
    chk("t3_high", hi, 20);
    chk("t3_other", oth, 0);
    wr(5'd4, 16'd0);
    wait_ps(60, n, nz);
    measure(40, -1, 16'h0, hi, oth);
    measure(40, -1, 16'h0, hi, oth);
    chk("t3_duty0", hi, 0);
    wr(5'd4, 16'd10);
    wait_ps(60, n, nz);
    measure(40, -1, 16'h0, hi, oth);
    measure(40, -1, 16'h0, hi, oth);
    chk("t3_duty_gt_period", hi, 40);

    do_reset();
    wr(5'd0, 16'h0020);
    chk("t4_pre", out[5], 0);
    step();
    chk("t4_on", out[5], 1);
    nz = 0;
    repeat (300) begin
      if (out != 16'h0020) nz++;
      step();
    end
    chk("t4_const", nz, 0);
    wr(5'd0, 16'h0000);
    chk("t4_hold", out[5], 1);
    step();
    chk("t4_off", out[5], 0);

    do_reset();
    wr(5'd0, 16'h0001);
    wr(5'd1, 16'h0001);
    wr(5'd4, 16'd128);
    wait_ps(400, n, nz);
    measure(256, -1, 16'h0, hi, oth);
    measure(256, 50, 16'd32, hi, oth);
    chk("t5_mid_nopartial", hi, 128);
    measure(256, -1, 16'h0, hi, oth);
    chk("t5_mid_next", hi, 32);
    measure(256, 10, 16'd128, hi, oth);
    chk("t5_restore", hi, 32);
    measure(256, 255, 16'd32, hi, oth);
    chk("t5_bnd_cur", hi, 128);
    measure(256, -1, 16'h0, hi, oth);
    chk("t5_bnd_next", hi, 128);
    measure(256, -1, 16'h0, hi, oth);
    chk("t5_bnd_after", hi, 32);

    wr(5'd0, 16'hFFFF);
    wr(5'd1, 16'h0000);
    wr(5'd3, 16'd3);
    repeat (20) step();
    chk("t6_pre_out", out, 16'hFFFF);
    rd(5'd0, 16'hFFFF, "t6_pre_rd");
    do_reset();
    chk("t6_rst_out", out, 0);
    chk("t6_rst_rdata", cfg_rdata, 0);
    chk("t6_rst_ps", period_start, 0);
    wait_ps(400, n, nz);
    chk("t6_cnt_restart", n, 256);
    chk("t6_idle", nz, 0);
    for (int i = 0; i < 7; i++) rd(vecs[i].addr, vecs[i].exp, $sformatf("t6_rst_vec%0d", i));

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
